// File: rtl/prio_enc8_seq_pkg.sv
// Shared constants, FSM state type and helpers for the sequential 8-to-3 priority encoder.
// Only eight request lines are supported; CODE_W is derived from N_IN.
package prio_enc8_pkg;

   localparam int N_IN   = 8;
   localparam int CODE_W = $clog2(N_IN);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   function automatic logic [N_IN-1:0] onehot(input logic [CODE_W-1:0] code);
      return N_IN'(1) << code;
   endfunction

endpackage

// File: rtl/prio_enc8_seq_if.sv
// Request/offer bus of the priority encoder: request pulses in, coded events out on valid/ready.
// Handshake: code_o is transferred on a rising clk edge where valid_o && ready_i; code_o is stable while valid_o && !ready_i.
interface prio_enc8_seq_if
   import prio_enc8_pkg::*;
#(
   parameter int CNT_W = 8
) ();

   logic [N_IN-1:0]   req_i;
   logic [CODE_W-1:0] code_o;
   logic              valid_o;
   logic              ready_i;
   logic [N_IN-1:0]   pend_o;
   logic              overflow_o;
   logic [CNT_W-1:0]  drop_cnt_o;

   // Encoder side.
   modport master (
      input  req_i,
      input  ready_i,
      output code_o,
      output valid_o,
      output pend_o,
      output overflow_o,
      output drop_cnt_o
   );

   // Event source plus consumer side.
   modport slave (
      output req_i,
      output ready_i,
      input  code_o,
      input  valid_o,
      input  pend_o,
      input  overflow_o,
      input  drop_cnt_o
   );

endinterface

// File: rtl/prio_enc8_seq_pick.sv
// Combinational search for the first set bit of vec, starting at index start (rr_en=1) or at 0 (rr_en=0).
// The search wraps from N_IN-1 back to 0.
module prio_pick8
   import prio_enc8_pkg::*;
(
   input  logic [N_IN-1:0]   vec,
   input  logic [CODE_W-1:0] start,
   input  logic              rr_en,
   output logic [CODE_W-1:0] code,
   output logic              found
);

   logic [CODE_W-1:0] base;
   logic [CODE_W-1:0] idx;

   assign base = rr_en ? start : '0;

   always_comb begin
      code  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_IN; i++) begin
         idx = base + CODE_W'(i);
         if (!found && vec[idx]) begin
            found = 1'b1;
            code  = idx;
         end
      end
   end

endmodule

// File: rtl/prio_enc8_seq.sv
// Sequential 8-to-3 priority encoder: captures request pulses into a pending vector and
// offers one pending index at a time, with sticky overflow and a saturating drop counter.
module prio_enc8_seq
   import prio_enc8_pkg::*;
#(
   parameter int ROUND_ROBIN = 0,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prio_enc8_seq_if.master       bus,
   output state_t                dbg_state
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state;
   logic [N_IN-1:0]   pending;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic [CODE_W-1:0] last_grant;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;

   logic              accept;
   logic [N_IN-1:0]   clr_mask;
   logic [N_IN-1:0]   rem;
   logic [N_IN-1:0]   pending_next;
   logic [N_IN-1:0]   drop_vec;
   logic [3:0]        drop_pc;
   logic [CNT_W+3:0]  cnt_sum;
   logic [CNT_W-1:0]  drop_cnt_next;

   logic [CODE_W-1:0] idle_code;
   logic              idle_found;
   logic [CODE_W-1:0] rem_code;
   logic              rem_found;

   localparam logic RR_EN = (ROUND_ROBIN != 0);

   assign accept       = valid && bus.ready_i;
   assign clr_mask     = accept ? onehot(code) : '0;
   // rem deliberately excludes same-cycle requests; those are picked up from pending later.
   assign rem          = pending & ~clr_mask;
   assign pending_next = rem | bus.req_i;
   assign drop_vec     = bus.req_i & rem;

   always_comb begin
      drop_pc = '0;
      for (int i = 0; i < N_IN; i++) begin
         drop_pc = drop_pc + 4'(drop_vec[i]);
      end
   end

   assign cnt_sum       = {4'b0, drop_cnt} + (CNT_W+4)'(drop_pc);
   assign drop_cnt_next = (cnt_sum > (CNT_W+4)'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

   prio_pick8 u_pick_idle (
      .vec   (pending),
      .start (last_grant + CODE_W'(1)),
      .rr_en (RR_EN),
      .code  (idle_code),
      .found (idle_found)
   );

   // On an accept, last_grant becomes code, so the rotating search restarts just past it.
   prio_pick8 u_pick_rem (
      .vec   (rem),
      .start (code + CODE_W'(1)),
      .rr_en (RR_EN),
      .code  (rem_code),
      .found (rem_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         code       <= '0;
         valid      <= 1'b0;
         last_grant <= CODE_W'(N_IN - 1);
         overflow   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         pending  <= pending_next;
         drop_cnt <= drop_cnt_next;
         if (|drop_vec) begin
            overflow <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (idle_found) begin
                  code  <= idle_code;
                  valid <= 1'b1;
                  state <= OFFER;
               end
            end
            OFFER: begin
               if (accept) begin
                  last_grant <= code;
                  if (rem_found) begin
                     code <= rem_code;
                  end else begin
                     valid <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.code_o     = code;
   assign bus.valid_o    = valid;
   assign bus.pend_o     = pending;
   assign bus.overflow_o = overflow;
   assign bus.drop_cnt_o = drop_cnt;
   assign dbg_state      = state;

endmodule

// File: tb/tb_prio_enc8_seq.sv
// Directed bench for prio_enc8_seq: a fixed-priority instance and a round-robin instance share clock and reset.
module tb_prio_enc8_seq;
   import prio_enc8_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t st_f;
   state_t st_r;
   int     tests = 0;
   int     fails = 0;

   prio_enc8_seq_if #(.CNT_W(8)) bus_f ();
   prio_enc8_seq_if #(.CNT_W(8)) bus_r ();

   prio_enc8_seq #(.ROUND_ROBIN(0), .CNT_W(8)) dut_f (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_f.master),
      .dbg_state (st_f)
   );

   prio_enc8_seq #(.ROUND_ROBIN(1), .CNT_W(8)) dut_r (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_r.master),
      .dbg_state (st_r)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus_f.req_i = '0; bus_f.ready_i = 1'b0;
      bus_r.req_i = '0; bus_r.ready_i = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      tests++; if (bus_f.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h want 0", bus_f.valid_o); end
      tests++; if (bus_f.code_o !== 3'd0) begin fails++; $display("FAIL reset_code: got %0h want 0", bus_f.code_o); end
      tests++; if (bus_f.pend_o !== 8'h00) begin fails++; $display("FAIL reset_pend: got %0h want 0", bus_f.pend_o); end
      tests++; if (bus_f.overflow_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0h want 0", bus_f.overflow_o); end
      tests++; if (bus_f.drop_cnt_o !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", bus_f.drop_cnt_o); end
      tests++; if (st_f !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", st_f); end
   endtask

   task automatic test_single();
      bus_f.req_i = 8'h20; bus_f.ready_i = 1'b1;
      step();
      bus_f.req_i = 8'h00;
      tests++; if (bus_f.pend_o !== 8'h20) begin fails++; $display("FAIL single_pend: got %0h want 20", bus_f.pend_o); end
      tests++; if (bus_f.valid_o !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %0h want 0", bus_f.valid_o); end
      step();
      tests++; if (bus_f.valid_o !== 1'b1 || bus_f.code_o !== 3'd5) begin fails++; $display("FAIL single_offer: got v=%0h c=%0d want v=1 c=5", bus_f.valid_o, bus_f.code_o); end
      step();
      tests++; if (bus_f.valid_o !== 1'b0 || bus_f.pend_o !== 8'h00) begin fails++; $display("FAIL single_done: got v=%0h p=%0h want v=0 p=0", bus_f.valid_o, bus_f.pend_o); end
   endtask

   task automatic test_fixed_burst();
      logic [2:0] exp_codes [3];
      exp_codes[0] = 3'd0; exp_codes[1] = 3'd4; exp_codes[2] = 3'd7;
      bus_f.req_i = 8'h91; bus_f.ready_i = 1'b1;
      step();
      bus_f.req_i = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (bus_f.valid_o !== 1'b1 || bus_f.code_o !== exp_codes[i]) begin fails++; $display("FAIL burst_code%0d: got v=%0h c=%0d want v=1 c=%0d", i, bus_f.valid_o, bus_f.code_o, exp_codes[i]); end
      end
      step();
      tests++; if (bus_f.valid_o !== 1'b0) begin fails++; $display("FAIL burst_end: got %0h want 0", bus_f.valid_o); end
   endtask

   task automatic test_backpressure();
      bus_f.req_i = 8'h40; bus_f.ready_i = 1'b0;
      step();
      bus_f.req_i = 8'h00;
      step();
      for (int c = 0; c < 5; c++) begin
         bus_f.req_i = (c == 1) ? 8'h01 : 8'h00;
         step();
         tests++; if (bus_f.valid_o !== 1'b1 || bus_f.code_o !== 3'd6) begin fails++; $display("FAIL bp_hold%0d: got v=%0h c=%0d want v=1 c=6", c, bus_f.valid_o, bus_f.code_o); end
      end
      bus_f.req_i = 8'h00; bus_f.ready_i = 1'b1;
      step();
      tests++; if (bus_f.valid_o !== 1'b1 || bus_f.code_o !== 3'd0) begin fails++; $display("FAIL bp_next: got v=%0h c=%0d want v=1 c=0", bus_f.valid_o, bus_f.code_o); end
      step();
      tests++; if (bus_f.valid_o !== 1'b0) begin fails++; $display("FAIL bp_end: got %0h want 0", bus_f.valid_o); end
   endtask

   task automatic test_round_robin();
      bus_r.req_i = 8'h40; bus_r.ready_i = 1'b1;
      step();
      bus_r.req_i = 8'h00;
      step();
      tests++; if (bus_r.code_o !== 3'd6 || bus_r.valid_o !== 1'b1) begin fails++; $display("FAIL rr_grant6: got v=%0h c=%0d want v=1 c=6", bus_r.valid_o, bus_r.code_o); end
      step();
      for (int r = 0; r < 2; r++) begin
         bus_r.req_i = 8'h82;
         step();
         bus_r.req_i = 8'h00;
         step();
         tests++; if (bus_r.code_o !== 3'd7 || bus_r.valid_o !== 1'b1) begin fails++; $display("FAIL rr_first%0d: got v=%0h c=%0d want v=1 c=7", r, bus_r.valid_o, bus_r.code_o); end
         step();
         tests++; if (bus_r.code_o !== 3'd1 || bus_r.valid_o !== 1'b1) begin fails++; $display("FAIL rr_second%0d: got v=%0h c=%0d want v=1 c=1", r, bus_r.valid_o, bus_r.code_o); end
         step();
         tests++; if (bus_r.valid_o !== 1'b0) begin fails++; $display("FAIL rr_idle%0d: got %0h want 0", r, bus_r.valid_o); end
      end
   endtask

   task automatic test_overflow();
      bus_f.ready_i = 1'b0; bus_f.req_i = 8'h08;
      step();
      bus_f.req_i = 8'h00;
      step();
      tests++; if (bus_f.code_o !== 3'd3 || bus_f.valid_o !== 1'b1) begin fails++; $display("FAIL ovf_offer: got v=%0h c=%0d want v=1 c=3", bus_f.valid_o, bus_f.code_o); end
      bus_f.req_i = 8'h08;
      step();
      bus_f.req_i = 8'h00;
      tests++; if (bus_f.overflow_o !== 1'b1 || bus_f.drop_cnt_o !== 8'd1) begin fails++; $display("FAIL ovf_first_drop: got o=%0h n=%0d want o=1 n=1", bus_f.overflow_o, bus_f.drop_cnt_o); end
      bus_f.ready_i = 1'b1; bus_f.req_i = 8'h08;
      step();
      bus_f.ready_i = 1'b0; bus_f.req_i = 8'h00;
      tests++; if (bus_f.drop_cnt_o !== 8'd1 || bus_f.pend_o !== 8'h08 || bus_f.valid_o !== 1'b0) begin fails++; $display("FAIL ovf_same_cycle: got n=%0d p=%0h v=%0h want n=1 p=08 v=0", bus_f.drop_cnt_o, bus_f.pend_o, bus_f.valid_o); end
      step();
      tests++; if (bus_f.code_o !== 3'd3 || bus_f.valid_o !== 1'b1) begin fails++; $display("FAIL ovf_reoffer: got v=%0h c=%0d want v=1 c=3", bus_f.valid_o, bus_f.code_o); end
      bus_f.req_i = 8'h0C;
      step();
      step();
      bus_f.req_i = 8'h00;
      tests++; if (bus_f.drop_cnt_o !== 8'd4) begin fails++; $display("FAIL ovf_multi_drop: got %0d want 4", bus_f.drop_cnt_o); end
      bus_f.req_i = 8'h08;
      repeat (300) step();
      bus_f.req_i = 8'h00;
      tests++; if (bus_f.drop_cnt_o !== 8'd255 || bus_f.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_saturate: got n=%0d o=%0h want n=255 o=1", bus_f.drop_cnt_o, bus_f.overflow_o); end
   endtask

   task automatic test_reset_mid();
      bus_r.ready_i = 1'b0; bus_r.req_i = 8'hFF;
      step();
      bus_r.req_i = 8'h00;
      step();
      tests++; if (bus_r.valid_o !== 1'b1 || bus_r.pend_o !== 8'hFF) begin fails++; $display("FAIL mid_pre: got v=%0h p=%0h want v=1 p=ff", bus_r.valid_o, bus_r.pend_o); end
      #3;
      rst_n = 1'b0;
      #1;
      tests++; if (bus_r.valid_o !== 1'b0 || bus_r.code_o !== 3'd0 || bus_r.pend_o !== 8'h00) begin fails++; $display("FAIL mid_clear: got v=%0h c=%0d p=%0h want 0 0 0", bus_r.valid_o, bus_r.code_o, bus_r.pend_o); end
      tests++; if (bus_f.overflow_o !== 1'b0 || bus_f.drop_cnt_o !== 8'd0) begin fails++; $display("FAIL mid_ovf_clear: got o=%0h n=%0d want 0 0", bus_f.overflow_o, bus_f.drop_cnt_o); end
      #2;
      rst_n = 1'b1;
      step();
      bus_r.req_i = 8'h81; bus_r.ready_i = 1'b1;
      step();
      bus_r.req_i = 8'h00;
      step();
      tests++; if (bus_r.code_o !== 3'd0 || bus_r.valid_o !== 1'b1) begin fails++; $display("FAIL mid_rr_start: got v=%0h c=%0d want v=1 c=0", bus_r.valid_o, bus_r.code_o); end
      step();
      tests++; if (bus_r.code_o !== 3'd7 || bus_r.valid_o !== 1'b1) begin fails++; $display("FAIL mid_rr_next: got v=%0h c=%0d want v=1 c=7", bus_r.valid_o, bus_r.code_o); end
      step();
      tests++; if (bus_r.valid_o !== 1'b0) begin fails++; $display("FAIL mid_rr_end: got %0h want 0", bus_r.valid_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fixed_burst();
      test_backpressure();
      test_round_robin();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
